// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data memory responder with fixed-latency request/response handshake
//
// Purpose: single-outstanding data memory for a pipeline MEM stage. A request
// is accepted in IDLE, held for LATENCY cycles, then answered in RESP until the
// requester consumes the response.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   ReqValid/ReqReady   request handshake
//   ReqWrite            1 = store, 0 = load
//   ReqSize             0 = word, 1 = halfword, 2 = byte, 3 = illegal
//   ReqAddr             byte address
//   ReqWData            right-justified store data
//   RespValid/RespReady response handshake
//   RespRData           zero-extended load data (0 for stores and errors)
//   RespErr             misaligned, out-of-range or illegal-size request
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    input  logic        RespReady,
    output logic [31:0] RespRData,
    output logic        RespErr
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;

    // Contents start at zero and are deliberately never touched by Rst.
    logic [31:0] r_mem [0:DEPTH_WORDS-1] = '{default: 32'h0};

    logic          w_req_ready;
    logic          w_accept;
    logic          w_done;
    logic          w_err;
    logic          w_oor;
    logic          w_commit;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_shift;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;

    // ---------------- FSM ----------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_req_ready = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = 1'b1;
                if (ReqValid) w_next = BUSY;
            end
            BUSY: begin
                if (r_cnt == 4'd0) w_next = RESP;
            end
            RESP: begin
                if (RespReady) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_accept = ReqValid && w_req_ready;
    // Last BUSY cycle: the response is captured and any store commits here.
    assign w_done   = (r_state == BUSY) && (r_cnt == 4'd0);

    // ---------------- request decode ----------------
    assign w_idx = r_addr[2 +: AW];
    assign w_oor = ({2'b00, r_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err = (r_size == 2'd3)
                || ((r_size == 2'd1) && r_addr[0])
                || ((r_size == 2'd0) && (r_addr[1:0] != 2'b00))
                || w_oor;

    assign w_word  = r_mem[w_idx];
    assign w_shift = w_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load  = 32'h0;
        w_be    = 4'h0;
        w_wlane = r_wdata;
        case (r_size)
            2'd0: begin
                w_load  = w_word;
                w_be    = 4'hF;
                w_wlane = r_wdata;
            end
            2'd1: begin
                w_load  = {16'h0, w_shift[15:0]};
                w_be    = r_addr[1] ? 4'hC : 4'h3;
                w_wlane = {2{r_wdata[15:0]}};
            end
            2'd2: begin
                w_load  = {24'h0, w_shift[7:0]};
                w_be    = 4'b0001 << r_addr[1:0];
                w_wlane = {4{r_wdata[7:0]}};
            end
            default: begin
                w_load = 32'h0;
                w_be   = 4'h0;
            end
        endcase
    end

    // A reset landing on the commit edge aborts the store.
    assign w_commit = w_done && r_write && !w_err && !Rst;

    // ---------------- datapath ----------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= ReqWrite;
                r_size  <= ReqSize;
                r_addr  <= ReqAddr;
                r_wdata <= ReqWData;
                r_cnt   <= 4'(LATENCY - 1);
            end else if ((r_state == BUSY) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_done) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? 32'h0 : w_load;
            end else if ((r_state == RESP) && RespReady) begin
                r_err   <= 1'b0;
                r_rdata <= 32'h0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
            end
        end
    end

    assign ReqReady  = w_req_ready;
    assign RespValid = (r_state == RESP);
    assign RespRData = r_rdata;
    assign RespErr   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_write  [3];
    logic [1:0]  req_size   [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int n_cmp = 0;
    int n_err = 0;

    // Instance 0: LATENCY=2, instance 1: LATENCY=1, instance 2: LATENCY=15.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_responder #(
            .DEPTH_WORDS(1024),
            .LATENCY    ((g == 0) ? 2 : ((g == 1) ? 1 : 15))
        ) u_dut (
            .Clk      (clk),
            .Rst      (rst),
            .ReqValid (req_valid[g]),
            .ReqReady (req_ready[g]),
            .ReqWrite (req_write[g]),
            .ReqSize  (req_size[g]),
            .ReqAddr  (req_addr[g]),
            .ReqWData (req_wdata[g]),
            .RespValid(resp_valid[g]),
            .RespReady(resp_ready[g]),
            .RespRData(resp_rdata[g]),
            .RespErr  (resp_err[g])
        );
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 1 : 15);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xact(input int d, input logic wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int hold, input string tag);
        int n;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_write[d] = wr;
        req_size[d]  = sz;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        check({tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        @(negedge clk);
        check({tag, "_busy_ready"}, 32'(req_ready[d]), 32'd0);
        n = 0;
        while (!resp_valid[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(lat_of(d)));
        check({tag, "_rdata"}, resp_rdata[d], exp_rd);
        check({tag, "_err"}, 32'(resp_err[d]), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            req_valid[d] = (i == 1);
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(resp_valid[d]), 32'd1);
            check({tag, "_hold_rdata"}, resp_rdata[d], exp_rd);
            check({tag, "_hold_err"}, 32'(resp_err[d]), 32'(exp_err));
            check({tag, "_hold_ready"}, 32'(req_ready[d]), 32'd0);
        end
        req_valid[d]  = 1'b0;
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready[d] = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, 32'(resp_valid[d]), 32'd0);
        check({tag, "_post_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_post_rdata"}, resp_rdata[d], 32'h0);
        check({tag, "_post_err"}, 32'(resp_err[d]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_size[d]   = 2'd0;
            req_addr[d]   = 32'h0;
            req_wdata[d]  = 32'h0;
            resp_ready[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_ready", 32'(req_ready[d]), 32'd1);
            check("rst_valid", 32'(resp_valid[d]), 32'd0);
            check("rst_rdata", resp_rdata[d], 32'h0);
            check("rst_err", 32'(resp_err[d]), 32'd0);
        end
        rst = 1'b0;

        // Word store / load round trip, LATENCY=2
        xact(0, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "st_w_10");
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "ld_w_10");

        // Byte lane write and sub-word loads
        xact(0, 1'b1, 2'd2, 32'h13, 32'h000000AA, 32'h0, 1'b0, 0, "st_b_13");
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0, 0, "ld_w_10b");
        xact(0, 1'b0, 2'd1, 32'h12, 32'h0, 32'h0000AAAD, 1'b0, 0, "ld_h_12");
        xact(0, 1'b0, 2'd2, 32'h10, 32'h0, 32'h000000EF, 1'b0, 0, "ld_b_10");

        // Error cases: misaligned half store, misaligned+OOR, aligned OOR, size 3
        xact(0, 1'b1, 2'd1, 32'h11, 32'h0000FFFF, 32'h0, 1'b1, 0, "st_h_11_err");
        xact(0, 1'b0, 2'd0, 32'h1002, 32'h0, 32'h0, 1'b1, 0, "ld_w_1002_err");
        xact(0, 1'b0, 2'd0, 32'h1000, 32'h0, 32'h0, 1'b1, 0, "ld_w_1000_err");
        xact(0, 1'b0, 2'd3, 32'h10, 32'h0, 32'h0, 1'b1, 0, "ld_sz3_err");

        // Backpressure for 3 cycles with a stray ReqValid pulse
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0, 3, "ld_w_hold");

        // Reset in the cycle after store acceptance aborts the store
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_size[0]  = 2'd0;
        req_addr[0]  = 32'h20;
        req_wdata[0] = 32'h12345678;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(req_ready[0]), 32'd1);
        check("abort_valid", 32'(resp_valid[0]), 32'd0);
        repeat (4) @(negedge clk);
        check("abort_no_resp", 32'(resp_valid[0]), 32'd0);
        xact(0, 1'b0, 2'd0, 32'h20, 32'h0, 32'h0, 1'b0, 0, "ld_w_20");
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'hAAADBEEF, 1'b0, 0, "ld_w_10_kept");

        // Halfword store to upper half ignores upper store bits
        xact(0, 1'b1, 2'd1, 32'h12, 32'hFFFF5566, 32'h0, 1'b0, 0, "st_h_12");
        xact(0, 1'b0, 2'd0, 32'h10, 32'h0, 32'h5566BEEF, 1'b0, 0, "ld_w_10c");
        xact(0, 1'b0, 2'd2, 32'h11, 32'h0, 32'h000000BE, 1'b0, 0, "ld_b_11");

        // Latency scaling: LATENCY=1 and LATENCY=15
        xact(1, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "l1_st");
        xact(1, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "l1_ld");
        xact(2, 1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "l15_st");
        xact(2, 1'b0, 2'd0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "l15_ld");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
